// File: rtl/vga16_pkg.sv
// Shared 640x480@60 VGA raster constants and the RGB565 pixel layout.
package vga16_pkg;

  localparam int CNT_W = 10;

  localparam logic [CNT_W-1:0] H_ACTIVE     = 10'd640;
  localparam logic [CNT_W-1:0] H_FP         = 10'd16;
  localparam logic [CNT_W-1:0] H_SYNC       = 10'd96;
  localparam logic [CNT_W-1:0] H_BP         = 10'd48;
  localparam logic [CNT_W-1:0] H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [CNT_W-1:0] H_SYNC_START = H_ACTIVE + H_FP;
  localparam logic [CNT_W-1:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [CNT_W-1:0] H_LAST       = H_TOTAL - 10'd1;

  localparam logic [CNT_W-1:0] V_ACTIVE     = 10'd480;
  localparam logic [CNT_W-1:0] V_FP         = 10'd10;
  localparam logic [CNT_W-1:0] V_SYNC       = 10'd2;
  localparam logic [CNT_W-1:0] V_BP         = 10'd33;
  localparam logic [CNT_W-1:0] V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] V_SYNC_START = V_ACTIVE + V_FP;
  localparam logic [CNT_W-1:0] V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam logic [CNT_W-1:0] V_LAST       = V_TOTAL - 10'd1;

  localparam int R_W     = 5;
  localparam int G_W     = 6;
  localparam int B_W     = 5;
  localparam int FRAME_W = B_W;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

endpackage

// File: rtl/vga_timing.sv
// VGA 800x525 raster counters with registered sync and active-area flags.
// Latency: syncs and flags lag the counters by one pixel enable.
// Backpressure: none; free-running, advances only when pe is high.
module vga_timing
  import vga16_pkg::*;
(
  input  logic             clk100,
  input  logic             reset,
  input  logic             pe,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hactive,
  output logic             vactive
);

  logic [CNT_W-1:0] hcount_nxt;
  logic [CNT_W-1:0] vcount_nxt;
  logic             h_last;
  logic             v_last;

  assign h_last = (hcount == H_LAST);
  assign v_last = (vcount == V_LAST);

  always_comb begin
    hcount_nxt = hcount;
    vcount_nxt = vcount;
    if (pe) begin
      hcount_nxt = h_last ? '0 : hcount + CNT_W'(1);
      if (h_last) begin
        vcount_nxt = v_last ? '0 : vcount + CNT_W'(1);
      end
    end
  end

  // Counters load every cycle; the hold value comes from the next-state logic.
  always_ff @(posedge clk100) begin
    if (reset) begin
      hcount  <= '0;
      vcount  <= '0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      hactive <= 1'b0;
      vactive <= 1'b0;
    end else begin
      hcount <= hcount_nxt;
      vcount <= vcount_nxt;
      if (pe) begin
        hsync   <= ~((hcount >= H_SYNC_START) && (hcount < H_SYNC_END));
        vsync   <= ~((vcount >= V_SYNC_START) && (vcount < V_SYNC_END));
        hactive <= (hcount < H_ACTIVE);
        vactive <= (vcount < V_ACTIVE);
      end
    end
  end

endmodule

// File: rtl/vga16_main.sv
// 640x480@60 VGA test-pattern generator, RGB565, pixel enable at clk100/4.
// Latency: sync and RGB lag the raster counters by one pixel enable.
// Backpressure: none; the raster is free-running.
module vga16_main
  import vga16_pkg::*;
(
  input  logic           clk100,
  input  logic           reset,
  output logic           pclk_out,
  output logic           hsync,
  output logic           vsync,
  output logic [R_W-1:0] red,
  output logic [G_W-1:0] green,
  output logic [B_W-1:0] blue
);

  logic [1:0]         div;
  logic               pe;
  logic [CNT_W-1:0]   hcount;
  logic [CNT_W-1:0]   vcount;
  logic               hactive;
  logic               vactive;
  logic               frame_wrap;
  logic [FRAME_W-1:0] frame;
  rgb565_t            pix;

  assign pe       = (div == 2'd3);
  assign pclk_out = div[1];

  always_ff @(posedge clk100) begin
    if (reset) div <= '0;
    else       div <= div + 2'd1;
  end

  vga_timing vga (
    .clk100  (clk100),
    .reset   (reset),
    .pe      (pe),
    .hcount  (hcount),
    .vcount  (vcount),
    .hsync   (hsync),
    .vsync   (vsync),
    .hactive (hactive),
    .vactive (vactive)
  );

  assign frame_wrap = pe && (hcount == H_LAST) && (vcount == V_LAST);

  always_ff @(posedge clk100) begin
    if (reset)           frame <= '0;
    else if (frame_wrap) frame <= frame + FRAME_W'(1);
  end

  // Pattern is captured on the same pe as the flags, so blanking lines up exactly.
  always_ff @(posedge clk100) begin
    if (reset) begin
      pix <= '0;
    end else if (pe) begin
      pix.r <= hcount[7:3];
      pix.g <= vcount[7:2];
      pix.b <= frame;
    end
  end

  assign red   = (hactive && vactive) ? pix.r : '0;
  assign green = (hactive && vactive) ? pix.g : '0;
  assign blue  = (hactive && vactive) ? pix.b : '0;

endmodule

// File: tb/tb_vga16_main.sv
// Bench for vga16_main: pixel-level reference model, directed table and raster sequences.
module tb_vga16_main;

  logic       clk100 = 1'b0;
  logic       reset  = 1'b1;
  logic       pclk_out, hsync, vsync;
  logic [4:0] red, blue;
  logic [5:0] green;

  vga16_main dut (
    .clk100   (clk100),
    .reset    (reset),
    .pclk_out (pclk_out),
    .hsync    (hsync),
    .vsync    (vsync),
    .red      (red),
    .green    (green),
    .blue     (blue)
  );

  always #5 clk100 = ~clk100;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // Reference state: prescaler phase, raster position and frame number as plain integers.
  int mdiv = 0, mh = 0, mv = 0, mf = 0;
  logic       e_hs = 1'b1, e_vs = 1'b1, e_ha = 1'b0, e_va = 1'b0;
  logic [4:0] e_r = '0, e_b = '0;
  logic [5:0] e_g = '0;
  logic [9:0] fh, fv;

  always @(posedge clk100) begin
    if (reset) begin
      mdiv = 0; mh = 0; mv = 0; mf = 0;
      e_hs = 1'b1; e_vs = 1'b1; e_ha = 1'b0; e_va = 1'b0;
      e_r = '0; e_g = '0; e_b = '0;
    end else begin
      if (mdiv == 3) begin
        e_ha = (mh < 640);
        e_va = (mv < 480);
        e_hs = !(mh >= 656 && mh < 752);
        e_vs = !(mv >= 490 && mv < 492);
        if (e_ha && e_va) begin
          e_r = 5'((mh / 8) % 32);
          e_g = 6'((mv / 4) % 64);
          e_b = 5'(mf);
        end else begin
          e_r = '0; e_g = '0; e_b = '0;
        end
        mh = mh + 1;
        if (mh == 800) begin
          mh = 0;
          mv = mv + 1;
          if (mv == 525) begin
            mv = 0;
            mf = (mf + 1) % 32;
          end
        end
      end
      mdiv = (mdiv + 1) % 4;
    end
  end

  always @(negedge clk100) begin
    if (chk_en) begin
      logic [20:0] got, exp;
      got = {pclk_out, hsync, vsync, dut.vga.hactive, dut.vga.vactive, red, green, blue};
      exp = {(mdiv >= 2), e_hs, e_vs, e_ha, e_va, e_r, e_g, e_b};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL cycle t=%0t got {pclk,hs,vs,ha,va,r,g,b}=%b expected %b", $time, got, exp);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to the falling edge right after the next pixel enable.
  task automatic pe_step();
    int n = 0;
    do begin
      @(negedge clk100);
      n++;
    end while (mdiv != 0 && n < 8);
    if (mdiv != 0) chk("pe_step_timeout", mdiv, 0);
  endtask

  // Teleport the raster so distant lines/frames are reachable in a short run.
  task automatic jump(input int h, input int v);
    if (mdiv != 0) pe_step();
    fh = 10'(h);
    fv = 10'(v);
    force dut.vga.hcount = fh;
    force dut.vga.vcount = fv;
    mh = h;
    mv = v;
    @(negedge clk100);
    release dut.vga.hcount;
    release dut.vga.vcount;
  endtask

  typedef struct {
    int         x, y;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    logic       hs, vs, act;
  } vec_t;

  vec_t tbl[16];
  int   hb[12] = '{637, 638, 639, 640, 654, 655, 656, 750, 751, 752, 797, 799};
  int   vb[10] = '{478, 479, 480, 488, 489, 490, 491, 492, 523, 524};

  initial begin
    tbl[0]  = '{x:100, y:200, r:5'd12, g:6'd50, b:5'd0, hs:1'b1, vs:1'b1, act:1'b1};
    tbl[1]  = '{x:639, y:479, r:5'd15, g:6'd55, b:5'd0, hs:1'b1, vs:1'b1, act:1'b1};
    tbl[2]  = '{x:640, y:0,   r:5'd0,  g:6'd0,  b:5'd0, hs:1'b1, vs:1'b1, act:1'b0};
    tbl[3]  = '{x:0,   y:480, r:5'd0,  g:6'd0,  b:5'd0, hs:1'b1, vs:1'b1, act:1'b0};
    tbl[4]  = '{x:655, y:5,   r:5'd0,  g:6'd0,  b:5'd0, hs:1'b1, vs:1'b1, act:1'b0};
    tbl[5]  = '{x:656, y:5,   r:5'd0,  g:6'd0,  b:5'd0, hs:1'b0, vs:1'b1, act:1'b0};
    tbl[6]  = '{x:751, y:5,   r:5'd0,  g:6'd0,  b:5'd0, hs:1'b0, vs:1'b1, act:1'b0};
    tbl[7]  = '{x:752, y:5,   r:5'd0,  g:6'd0,  b:5'd0, hs:1'b1, vs:1'b1, act:1'b0};
    tbl[8]  = '{x:10,  y:489, r:5'd0,  g:6'd0,  b:5'd0, hs:1'b1, vs:1'b1, act:1'b0};
    tbl[9]  = '{x:10,  y:490, r:5'd0,  g:6'd0,  b:5'd0, hs:1'b1, vs:1'b0, act:1'b0};
    tbl[10] = '{x:700, y:491, r:5'd0,  g:6'd0,  b:5'd0, hs:1'b0, vs:1'b0, act:1'b0};
    tbl[11] = '{x:10,  y:492, r:5'd0,  g:6'd0,  b:5'd0, hs:1'b1, vs:1'b1, act:1'b0};
    tbl[12] = '{x:0,   y:0,   r:5'd0,  g:6'd0,  b:5'd0, hs:1'b1, vs:1'b1, act:1'b1};
    tbl[13] = '{x:8,   y:4,   r:5'd1,  g:6'd1,  b:5'd0, hs:1'b1, vs:1'b1, act:1'b1};
    tbl[14] = '{x:255, y:255, r:5'd31, g:6'd63, b:5'd0, hs:1'b1, vs:1'b1, act:1'b1};
    tbl[15] = '{x:256, y:256, r:5'd0,  g:6'd0,  b:5'd0, hs:1'b1, vs:1'b1, act:1'b1};

    @(negedge clk100);
    chk_en = 1'b1;
    repeat (2) @(negedge clk100);
    chk("rst_pclk", pclk_out, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_rgb", {red, green, blue}, 0);
    chk("rst_hactive", dut.vga.hactive, 0);
    chk("rst_vactive", dut.vga.vactive, 0);
    reset = 1'b0;

    // pclk_out phase/period and first-pixel latency after release.
    begin
      int   rise_at[$];
      logic prev;
      prev = pclk_out;
      for (int c = 1; c <= 16; c++) begin
        @(negedge clk100);
        if (c == 1) chk("pclk_after_edge1", pclk_out, 0);
        if (c == 2) chk("pclk_after_edge2", pclk_out, 1);
        if (c == 3) chk("active_before_first_pe", dut.vga.hactive & dut.vga.vactive, 0);
        if (c == 4) begin
          chk("first_pixel_active", dut.vga.hactive & dut.vga.vactive, 1);
          chk("first_pixel_rgb", {red, green, blue}, 0);
        end
        if (pclk_out && !prev) rise_at.push_back(c);
        prev = pclk_out;
      end
      chk("pclk_rise_count", rise_at.size(), 4);
      if (rise_at.size() >= 2) chk("pclk_period_ns", (rise_at[1] - rise_at[0]) * 10, 40);
    end

    // hsync period/width and active pixels per line, free-running from (4,0).
    begin
      int   fall1, fall2, low, act_cnt;
      logic prev;
      fall1 = -1; fall2 = -1; low = -1; act_cnt = 0;
      prev = hsync;
      for (int i = 1; i <= 1700; i++) begin
        pe_step();
        if (prev && !hsync) begin
          if (fall1 < 0) fall1 = i;
          else if (fall2 < 0) fall2 = i;
        end
        if (!prev && hsync && fall1 >= 0 && low < 0) low = i - fall1;
        if (i <= 800 && dut.vga.hactive && dut.vga.vactive) act_cnt++;
        prev = hsync;
      end
      chk("hsync_period_px", fall2 - fall1, 800);
      chk("hsync_low_px", low, 96);
      chk("active_px_per_line", act_cnt, 640);
    end

    for (int i = 0; i < 16; i++) begin
      jump(tbl[i].x, tbl[i].y);
      pe_step();
      chk($sformatf("tbl%0d_rgb", i), {red, green, blue}, {tbl[i].r, tbl[i].g, tbl[i].b});
      chk($sformatf("tbl%0d_sync", i), {hsync, vsync}, {tbl[i].hs, tbl[i].vs});
      chk($sformatf("tbl%0d_active", i), dut.vga.hactive & dut.vga.vactive, tbl[i].act);
    end

    // vsync: falls on line 490, low for exactly two lines.
    jump(700, 488);
    begin
      int   fall, low;
      logic prev;
      fall = -1; low = -1;
      prev = vsync;
      for (int i = 1; i <= 2700; i++) begin
        pe_step();
        if (prev && !vsync && fall < 0) fall = i;
        if (!prev && vsync && fall >= 0 && low < 0) low = i - fall;
        prev = vsync;
      end
      chk("vsync_fall_px", fall, 901);
      chk("vsync_low_px", low, 1600);
    end

    // Frame counter: 33 end-of-frame wraps, blue shows the frame number at (0,0).
    for (int k = 1; k <= 33; k++) begin
      jump(799, 524);
      pe_step();
      chk("wrap_pixel_blank", {red, green, blue}, 0);
      pe_step();
      chk($sformatf("frame%0d_blue", k), blue, k % 32);
    end

    // Mid-line reset.
    jump(300, 100);
    repeat (5) pe_step();
    chk("pre_reset_blue", blue, 1);
    reset = 1'b1;
    @(negedge clk100);
    chk("midrst_pclk", pclk_out, 0);
    chk("midrst_sync", {hsync, vsync}, 2'b11);
    chk("midrst_rgb", {red, green, blue}, 0);
    chk("midrst_active", {dut.vga.hactive, dut.vga.vactive}, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk100);
    chk("postrst_first_active", dut.vga.hactive & dut.vga.vactive, 1);
    chk("postrst_first_rgb", {red, green, blue}, 0);

    // Random jumps, boundary-biased positions and random reset pulses.
    for (int it = 0; it < 40; it++) begin
      int r, h, v;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        reset = 1'b1;
        @(negedge clk100);
        reset = 1'b0;
      end else begin
        if (r < 6) begin
          h = $urandom_range(0, 799);
          v = $urandom_range(0, 524);
        end else begin
          h = hb[$urandom_range(0, 11)];
          v = vb[$urandom_range(0, 9)];
        end
        jump(h, v);
      end
      repeat ($urandom_range(4, 300)) @(negedge clk100);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
